wb_dual_master_arbiter: RTL
===========================

Name: wb_dual_master_arbiter

Overview:
- Shares one Wishbone classic slave port between two Wishbone masters.
  - m0: the instruction-side ahb_to_wishbone adapter.
  - m1: the data-side ahb_to_wishbone adapter.
- Used when ENABLE_SECOND_MEMORY is undefined and the Controller exposes only the core_* bus.
- Round-robin arbitration; a grant is held for the whole cyc period.
- A stalled slave is aborted by a timeout that returns err to the owning master.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; the wstrb width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, stb-without-ack cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  core clock (clk_core domain).
- rst_n  in  1  synchronous active-low reset.
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 Wishbone controls.
- m0_wstrb  in  DATA_WIDTH/8  master 0 byte strobes.
- m0_adr  in  ADDR_WIDTH  master 0 address.
- m0_dat_w  in  DATA_WIDTH  master 0 write data.
- m0_dat_r  out  DATA_WIDTH  master 0 read data.
- m0_ack, m0_err  out  1 each  master 0 ack and error.
- m1_cyc, m1_stb, m1_we, m1_wstrb, m1_adr, m1_dat_w, m1_dat_r, m1_ack, m1_err  same as m0, for master 1.
- s_cyc, s_stb, s_we  out  1 each  slave controls.
- s_wstrb  out  DATA_WIDTH/8  slave byte strobes.
- s_adr  out  ADDR_WIDTH  slave address.
- s_dat_w  out  DATA_WIDTH  slave write data.
- s_dat_r  in  DATA_WIDTH  slave read data.
- s_ack  in  1  slave ack.
- timeout_o  out  1  one-cycle pulse on abort.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-low (rst_n).
- Request definition: reqX = mX_cyc & mX_stb.
- FSM states:
  - IDLE.
  - GNT0.
  - GNT1.
  - Reset: state=IDLE, last_grant=1 (so m0 wins the first tie), timeout counter=0, timeout_o=0.
- IDLE transitions:
  - req0 only -> GNT0.
  - req1 only -> GNT1.
  - Both -> the master not equal to last_grant.
  - Neither -> stay in IDLE.
  - Arbitration latency is 1 cycle: a request seen in IDLE appears on s_* in the following cycle.
- GNTx behaviour:
  - s_cyc/s_stb/s_we/s_wstrb/s_adr/s_dat_w are combinationally muxed from master x.
  - mx_ack = s_ack.
  - The other master's ack and err are 0.
  - last_grant <= x on entry.
- GNTx release:
  - GNTx -> IDLE when mx_cyc=0; s_cyc drops in that same cycle (combinational).
  - The grant is held across multiple stb beats while mx_cyc=1 (lock semantics, no preemption).
  - One IDLE cycle always separates grants.
- Outputs in IDLE: all s_* outputs are 0.
- Read data: s_dat_r is broadcast to both mX_dat_r at all times (value qualified by ack).
- Timeout counter:
  - Increments each cycle in GNTx with mx_stb=1 and s_ack=0.
  - Clears on s_ack, on leaving GNTx, or when stb=0.
- Timeout abort: if TIMEOUT_CYCLES!=0 and count==TIMEOUT_CYCLES-1 with no ack:
  - mx_err=1 for exactly that cycle; no ack.
  - timeout_o=1 for that cycle.
  - Next state is IDLE; s_cyc and s_stb are forced 0 from the next cycle, even if mx_cyc is still 1.
  - A master still holding cyc re-arbitrates from IDLE.
- Simultaneous s_ack and timeout in the same cycle: ack wins; no err, no timeout_o.
- Reset mid-transaction: next cycle state=IDLE and all s_* outputs 0; any in-flight slave response is ignored.
- Stray s_ack while IDLE: ignored; no mX_ack asserted.

Decomposition:
- Package wb_arb_pkg:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_GNT0, ARB_GNT1} arb_state_t.
  - Localparam for the timeout counter width, $clog2(TIMEOUT_CYCLES+1).
- Sub-module wb_arb_timeout:
  - Counter with enable, clear and expire output, parameterised by TIMEOUT_CYCLES.
  - Tied off (expire=0) when TIMEOUT_CYCLES=0.
- The top level contains the FSM, last_grant register and output muxes.

Test Plan:
- Single read: m0 reads adr 0x100, slave acks after 2 cycles with 0xDEADBEEF -> s_stb seen 1 cycle after request; m0_ack=1 with m0_dat_r=0xDEADBEEF; m1_ack=0.
- Tie after reset: m0 and m1 request in the same cycle -> m0 granted first. After m0_cyc drops: 1 IDLE cycle, then m1 (adr 0x2004, we=1, wstrb=4'b0011) appears on s_*.
- Fairness: both masters request continuously, each releasing after 1 beat -> grants alternate 0,1,0,1 over 8 transactions.
- Lock: m1 does 3 stb beats under one cyc while m0 requests -> m0 is not granted until m1_cyc=0.
- Timeout: TIMEOUT_CYCLES=8, slave never acks m0 -> m0_err and timeout_o pulse in the 8th stb cycle; s_cyc=0 the next cycle. Ack arriving in the 8th cycle -> ack, no err.
- Reset mid-transaction: rst_n=0 during GNT1 with the ack pending -> next cycle all s_* are 0 and state is IDLE. A later tie grants m0 first.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the dual-master Wishbone arbiter.
`timescale 1ns/1ps
package wb_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_GNT0 = 2'd1,
      ARB_GNT1 = 2'd2
   } arb_state_t;

   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

   // Timeout counter width, $clog2(TIMEOUT_CYCLES+1), never narrower than one bit
   function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
      return (cycles == 0) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Stall watchdog: counts stb-without-ack cycles and flags expiry on the last one.
`timescale 1ns/1ps
module wb_arb_timeout
   import wb_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic expire
);

   if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_tie;
      assign unused_tie = ^{clk, rst_n, en, clr};
      assign expire     = 1'b0;
   end else begin : g_on
      localparam int unsigned    CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

      logic [CNT_W-1:0] cnt;

      // An ack in the final cycle clears instead of expiring, so ack wins
      assign expire = en && !clr && (cnt == LAST);

      // Count stalled cycles; any ack, idle stb or abort restarts from zero
      always_ff @(posedge clk) begin
         if (!rst_n || clr || !en || expire) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/wb_dual_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic slave between two masters.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ARB_IDLE | no owner; all s_* low; arbitrate requests for next cycle
//   ARB_GNT0 | m0 owns the slave until m0_cyc drops or the stall aborts
//   ARB_GNT1 | m1 owns the slave until m1_cyc drops or the stall aborts
`timescale 1ns/1ps
module wb_dual_master_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    m0_cyc,
   input  logic                    m0_stb,
   input  logic                    m0_we,
   input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
   input  logic [ADDR_WIDTH-1:0]   m0_adr,
   input  logic [DATA_WIDTH-1:0]   m0_dat_w,
   output logic [DATA_WIDTH-1:0]   m0_dat_r,
   output logic                    m0_ack,
   output logic                    m0_err,
   input  logic                    m1_cyc,
   input  logic                    m1_stb,
   input  logic                    m1_we,
   input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
   input  logic [ADDR_WIDTH-1:0]   m1_adr,
   input  logic [DATA_WIDTH-1:0]   m1_dat_w,
   output logic [DATA_WIDTH-1:0]   m1_dat_r,
   output logic                    m1_ack,
   output logic                    m1_err,
   output logic                    s_cyc,
   output logic                    s_stb,
   output logic                    s_we,
   output logic [DATA_WIDTH/8-1:0] s_wstrb,
   output logic [ADDR_WIDTH-1:0]   s_adr,
   output logic [DATA_WIDTH-1:0]   s_dat_w,
   input  logic [DATA_WIDTH-1:0]   s_dat_r,
   input  logic                    s_ack,
   output logic                    timeout_o
);

   arb_state_t state, state_nxt;
   logic       last_grant;
   logic       req0, req1;
   logic       gnt0, gnt1;
   logic       expire;

   assign req0 = m0_cyc & m0_stb;
   assign req1 = m1_cyc & m1_stb;
   assign gnt0 = (state == ARB_GNT0);
   assign gnt1 = (state == ARB_GNT1);

   wb_arb_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (s_stb),
      .clr    (!(gnt0 || gnt1) || s_ack),
      .expire (expire)
   );

   // Arbitration: ties go to whichever master did not own the bus last
   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE: begin
            if (req0 && (!req1 || last_grant)) begin
               state_nxt = ARB_GNT0;
            end else if (req1) begin
               state_nxt = ARB_GNT1;
            end
         end
         ARB_GNT0: if (!m0_cyc || expire) state_nxt = ARB_IDLE;
         ARB_GNT1: if (!m1_cyc || expire) state_nxt = ARB_IDLE;
         default:  state_nxt = ARB_IDLE;
      endcase
   end

   // State and last-owner registers; last_grant=1 lets m0 win the first tie
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ARB_IDLE;
         last_grant <= 1'b1;
      end else begin
         state <= state_nxt;
         if (state == ARB_IDLE && state_nxt == ARB_GNT0) begin
            last_grant <= 1'b0;
         end else if (state == ARB_IDLE && state_nxt == ARB_GNT1) begin
            last_grant <= 1'b1;
         end
      end
   end

   // Slave-side mux; cyc follows the owner combinationally so release is immediate
   always_comb begin
      s_cyc   = 1'b0;
      s_stb   = 1'b0;
      s_we    = 1'b0;
      s_wstrb = '0;
      s_adr   = '0;
      s_dat_w = '0;
      if (gnt0) begin
         s_cyc   = m0_cyc;
         s_stb   = m0_stb;
         s_we    = m0_we;
         s_wstrb = m0_wstrb;
         s_adr   = m0_adr;
         s_dat_w = m0_dat_w;
      end else if (gnt1) begin
         s_cyc   = m1_cyc;
         s_stb   = m1_stb;
         s_we    = m1_we;
         s_wstrb = m1_wstrb;
         s_adr   = m1_adr;
         s_dat_w = m1_dat_w;
      end
   end

   assign m0_ack    = gnt0 & s_ack;
   assign m1_ack    = gnt1 & s_ack;
   assign m0_err    = gnt0 & expire;
   assign m1_err    = gnt1 & expire;
   assign m0_dat_r  = s_dat_r;
   assign m1_dat_r  = s_dat_r;
   assign timeout_o = expire;

endmodule
